// File: rtl/ui_io_controller.sv
// ============================================================================
// ui_io_controller
// ----------------------------------------------------------------------------
// Memory-mapped controller for board user I/O: push-buttons, slide switches,
// red LEDs and seven-segment hex displays. Keys and switches are
// synchronised, counter-debounced per bit, and tracked with sticky
// change-detect status (ready / overrun) and a maskable interrupt.
//
// Register map (uiDevice):
//   0 KDATA  RO  {0, ~keyDeb}   (1 = pressed)
//   1 SDATA  RO  {0, swDeb}
//   2 LEDR   RW  {0, led}
//   3 HEX    RW  {0, hex nibbles}
//   4 KCTRL  RW  bit0 ready (RO), bit2 overrun (write 0 clears), bit8 ie
//   5 SCTRL  RW  same layout as KCTRL, for switches
//   6-7      reserved: read 0, writes ignored
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   wrtEn     in   write strobe for the selected register
//   rdEn      in   read-acknowledge strobe (clears ready on a DATA read)
//   uiDevice  in   3-bit register select
//   in        in   write data
//   KEYS      in   raw push-buttons, 0 = pressed
//   SWITCHES  in   raw slide switches
//   out       out  combinational read data, zero-extended
//   LED       out  LED drive
//   HEX       out  seven-segment drive, digit i on HEX[7i+6:7i], active-low
//   irq       out  (kIe & kReady) | (sIe & sReady)
// ============================================================================

// ----------------------------------------------------------------------------
// ui_io_debounce
// ----------------------------------------------------------------------------
// Two-flop synchroniser followed by a per-bit counter debouncer. A bit's
// debounced value follows its synchronised value only after the two have
// disagreed for DEB_CYCLES consecutive cycles.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   raw_i  in   raw asynchronous inputs
//   deb_o  out  debounced vector
//   chg_o  out  high in the cycle whose closing edge changes deb_o
// ----------------------------------------------------------------------------
module ui_io_debounce #(
   parameter int   W          = 4,
   parameter int   DEB_CYCLES = 256,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] deb_o,
   output logic         chg_o
);

   localparam int            CW      = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [W-1:0]  sync1_q;
   logic [W-1:0]  sync2_q;
   logic [W-1:0]  deb_q;
   logic [W-1:0]  deb_d;
   logic [CW-1:0] cnt_q [W];
   logic [CW-1:0] cnt_d [W];

   // NOTE: every output of a combinational block is assigned a default at
   // the top, so no path leaves a variable unassigned and no latch appears.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < W; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // values from before the edge; blocking here would chain the synchroniser
   // stages into a single flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= {W{RST_VAL}};
         sync2_q <= {W{RST_VAL}};
         deb_q   <= {W{RST_VAL}};
         // NOTE: the counter array is reset explicitly: it is a handful of
         // flops, and a reset landing mid-debounce must not leave a partial
         // count that shortens the next debounce.
         for (int i = 0; i < W; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         for (int i = 0; i < W; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign deb_o = deb_q;
   assign chg_o = |(deb_d ^ deb_q);

endmodule

// ----------------------------------------------------------------------------
// ui_io_controller (top)
// ----------------------------------------------------------------------------
module ui_io_controller #(
   parameter int DBITS      = 32,
   parameter int NKEYS      = 4,
   parameter int NSW        = 10,
   parameter int NLED       = 10,
   parameter int NHEX       = 4,
   parameter int DEB_CYCLES = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wrtEn,
   input  logic              rdEn,
   input  logic [2:0]        uiDevice,
   input  logic [DBITS-1:0]  in,
   input  logic [NKEYS-1:0]  KEYS,
   input  logic [NSW-1:0]    SWITCHES,
   output logic [DBITS-1:0]  out,
   output logic [NLED-1:0]   LED,
   output logic [7*NHEX-1:0] HEX,
   output logic              irq
);

   typedef enum logic [2:0] {
      DEV_KDATA = 3'd0,
      DEV_SDATA = 3'd1,
      DEV_LEDR  = 3'd2,
      DEV_HEX   = 3'd3,
      DEV_KCTRL = 3'd4,
      DEV_SCTRL = 3'd5,
      DEV_RSV6  = 3'd6,
      DEV_RSV7  = 3'd7
   } ui_dev_e;

   typedef struct packed {
      logic ie;
      logic ovr;
      logic ready;
   } stat_t;

   ui_dev_e dev;
   assign dev = ui_dev_e'(uiDevice);

   // ---------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------
   logic [NKEYS-1:0] key_deb;
   logic [NSW-1:0]   sw_deb;
   logic             key_evt;
   logic             sw_evt;

   // Keys are active-low, so their idle (released) level is 1.
   ui_io_debounce #(
      .W          (NKEYS),
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (1'b1)
   ) u_key_deb (
      .clk   (clk),
      .reset (reset),
      .raw_i (KEYS),
      .deb_o (key_deb),
      .chg_o (key_evt)
   );

   ui_io_debounce #(
      .W          (NSW),
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (1'b0)
   ) u_sw_deb (
      .clk   (clk),
      .reset (reset),
      .raw_i (SWITCHES),
      .deb_o (sw_deb),
      .chg_o (sw_evt)
   );

   // ---------------------------------------------------------------------
   // Status next-state. A CTRL write updates ie and may clear overrun; a
   // change event then takes precedence so a new overrun is never lost.
   // An event coinciding with a clearing read leaves ready set and overrun
   // untouched, since the read consumed the previous event.
   // ---------------------------------------------------------------------
   function automatic stat_t stat_next(
      input stat_t cur,
      input logic  evt,
      input logic  clr_rd,
      input logic  wr_ctrl,
      input logic  ie_w,
      input logic  keep_ovr
   );
      stat_t nxt;
      nxt = cur;
      if (wr_ctrl) begin
         nxt.ie = ie_w;
         if (!keep_ovr) begin
            nxt.ovr = 1'b0;
         end
      end
      if (evt) begin
         if (cur.ready && !clr_rd) begin
            nxt.ovr = 1'b1;
         end
         nxt.ready = 1'b1;
      end else if (clr_rd) begin
         nxt.ready = 1'b0;
      end
      return nxt;
   endfunction

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   logic [NLED-1:0]   led_q,  led_d;
   logic [4*NHEX-1:0] hex_q,  hex_d;
   stat_t             kst_q,  kst_d;
   stat_t             sst_q,  sst_d;

   always_comb begin
      led_d = led_q;
      hex_d = hex_q;
      if (wrtEn && dev == DEV_LEDR) begin
         led_d = in[NLED-1:0];
      end
      if (wrtEn && dev == DEV_HEX) begin
         hex_d = in[4*NHEX-1:0];
      end
      kst_d = stat_next(kst_q, key_evt, rdEn && dev == DEV_KDATA,
                        wrtEn && dev == DEV_KCTRL, in[8], in[2]);
      sst_d = stat_next(sst_q, sw_evt, rdEn && dev == DEV_SDATA,
                        wrtEn && dev == DEV_SCTRL, in[8], in[2]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q <= '0;
         hex_q <= '0;
         kst_q <= '0;
         sst_q <= '0;
      end else begin
         led_q <= led_d;
         hex_q <= hex_d;
         kst_q <= kst_d;
         sst_q <= sst_d;
      end
   end

   // ---------------------------------------------------------------------
   // Read mux (combinational, zero-extended)
   // ---------------------------------------------------------------------
   always_comb begin
      out = '0;
      case (dev)
         DEV_KDATA: out[NKEYS-1:0]  = ~key_deb;
         DEV_SDATA: out[NSW-1:0]    = sw_deb;
         DEV_LEDR:  out[NLED-1:0]   = led_q;
         DEV_HEX:   out[4*NHEX-1:0] = hex_q;
         DEV_KCTRL: begin
            out[0] = kst_q.ready;
            out[2] = kst_q.ovr;
            out[8] = kst_q.ie;
         end
         DEV_SCTRL: begin
            out[0] = sst_q.ready;
            out[2] = sst_q.ovr;
            out[8] = sst_q.ie;
         end
         default: out = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   // Segment order {g,f,e,d,c,b,a}, active-low.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   for (genvar g = 0; g < NHEX; g++) begin : g_hex
      assign HEX[7*g +: 7] = seg7(hex_q[4*g +: 4]);
   end

   assign LED = led_q;
   assign irq = (kst_q.ie & kst_q.ready) | (sst_q.ie & sst_q.ready);

   // Only a few bits of the write bus are decoded; fold the rest away.
   logic unused_in;
   assign unused_in = ^in;

endmodule

// File: tb/tb_ui_io_controller.sv
module tb_ui_io_controller;

   localparam int DBITS = 32;
   localparam int NKEYS = 4;
   localparam int NSW   = 10;
   localparam int NLED  = 10;
   localparam int NHEX  = 4;
   localparam int DEB   = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              wrtEn;
   logic              rdEn;
   logic [2:0]        uiDevice;
   logic [DBITS-1:0]  in;
   logic [NKEYS-1:0]  KEYS;
   logic [NSW-1:0]    SWITCHES;
   logic [DBITS-1:0]  out;
   logic [NLED-1:0]   LED;
   logic [7*NHEX-1:0] HEX;
   logic              irq;

   ui_io_controller #(
      .DBITS (DBITS), .NKEYS (NKEYS), .NSW (NSW),
      .NLED (NLED), .NHEX (NHEX), .DEB_CYCLES (DEB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wrtEn    (wrtEn),
      .rdEn     (rdEn),
      .uiDevice (uiDevice),
      .in       (in),
      .KEYS     (KEYS),
      .SWITCHES (SWITCHES),
      .out      (out),
      .LED      (LED),
      .HEX      (HEX),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   typedef enum int {K_OUT, K_LED, K_HEX, K_IRQ} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   // Scoreboard push: the monitor compares it at the next falling edge.
   task automatic expect_v(input kind_e k, input logic [31:0] v, input string nm);
      exp_t e;
      e.kind = k;
      e.exp  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   // Monitor: samples DUT outputs on the falling edge, away from the active edge.
   exp_t        mon_e;
   logic [31:0] mon_act;
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         case (mon_e.kind)
            K_OUT:   mon_act = out;
            K_LED:   mon_act = 32'(LED);
            K_HEX:   mon_act = 32'(HEX);
            default: mon_act = 32'(irq);
         endcase
         check(mon_e.name, mon_act, mon_e.exp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [2:0] d, input logic [31:0] v);
      uiDevice = d;
      in       = v;
      wrtEn    = 1'b1;
      tick();
      wrtEn    = 1'b0;
   endtask

   task automatic rd_ack(input logic [2:0] d);
      uiDevice = d;
      rdEn     = 1'b1;
      tick();
      rdEn     = 1'b0;
   endtask

   task automatic chk_rd(input logic [2:0] d, input logic [31:0] v, input string nm);
      uiDevice = d;
      expect_v(K_OUT, v, nm);
      tick();
   endtask

   localparam logic [27:0] HEX_ZERO = {4{7'h40}};
   // Digits 3..0 show B,E,E,F for 16'hBEEF.
   localparam logic [27:0] HEX_BEEF = {7'h03, 7'h06, 7'h06, 7'h0E};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      wrtEn    = 1'b0;
      rdEn     = 1'b0;
      uiDevice = 3'd0;
      in       = '0;
      KEYS     = '1;
      SWITCHES = '0;
      ticks(2);
      reset = 1'b0;
      tick();

      // Load non-reset state, then assert reset asynchronously mid-cycle.
      wr(3'd2, 32'h3FF);
      wr(3'd3, 32'h1234);
      wr(3'd4, 32'h100);
      expect_v(K_LED, 32'h3FF, "led_preload");
      tick();
      @(posedge clk);
      #3;
      reset    = 1'b1;
      uiDevice = 3'd0;
      expect_v(K_LED, 32'h0, "rst_led");
      expect_v(K_HEX, 32'(HEX_ZERO), "rst_hex");
      expect_v(K_IRQ, 32'h0, "rst_irq");
      expect_v(K_OUT, 32'h0, "rst_out_dev0");
      for (int d = 1; d < 8; d++) begin
         tick();
         uiDevice = 3'(d);
         expect_v(K_OUT, 32'h0, $sformatf("rst_out_dev%0d", d));
      end
      tick();
      reset = 1'b0;
      tick();

      // Write / readback and masking of unused or read-only codes.
      wr(3'd2, 32'h3A5);
      wr(3'd3, 32'hBEEF);
      expect_v(K_LED, 32'h3A5, "led_3a5");
      expect_v(K_HEX, 32'(HEX_BEEF), "hex_beef");
      chk_rd(3'd2, 32'h0000_03A5, "rd_ledr");
      chk_rd(3'd3, 32'h0000_BEEF, "rd_hex");
      wr(3'd6, 32'hFFFF_FFFF);
      wr(3'd7, 32'hFFFF_FFFF);
      wr(3'd0, 32'hFFFF_FFFF);
      wr(3'd1, 32'hFFFF_FFFF);
      expect_v(K_LED, 32'h3A5, "led_after_bad_wr");
      expect_v(K_HEX, 32'(HEX_BEEF), "hex_after_bad_wr");
      chk_rd(3'd6, 32'h0, "rd_rsv6");
      chk_rd(3'd7, 32'h0, "rd_rsv7");
      chk_rd(3'd0, 32'h0, "rd_kdata_idle");
      chk_rd(3'd1, 32'h0, "rd_sdata_idle");
      chk_rd(3'd4, 32'h0, "rd_kctrl_idle");
      chk_rd(3'd5, 32'h0, "rd_sctrl_idle");
      wr(3'd2, 32'hFFFF_FC5A);
      expect_v(K_LED, 32'h05A, "led_truncated");
      chk_rd(3'd2, 32'h0000_005A, "rd_ledr_truncated");

      // Debounce: a 5-cycle glitch is rejected.
      uiDevice = 3'd0;
      KEYS     = 4'b1101;
      ticks(5);
      KEYS     = 4'b1111;
      ticks(15);
      chk_rd(3'd0, 32'h0, "glitch_kdata");
      chk_rd(3'd4, 32'h0, "glitch_kctrl");

      // Held press appears exactly 2 + DEB cycles after the raw edge.
      uiDevice = 3'd0;
      KEYS     = 4'b1101;
      ticks(9);
      expect_v(K_OUT, 32'h0, "kdata_one_before");
      tick();
      expect_v(K_OUT, 32'h2, "kdata_at_latency");
      tick();
      chk_rd(3'd4, 32'h1, "kctrl_ready");

      // Interrupt on key press, cleared by a KDATA read acknowledge.
      rd_ack(3'd0);
      chk_rd(3'd4, 32'h0, "kctrl_ack_clear");
      wr(3'd4, 32'h100);
      expect_v(K_IRQ, 32'h0, "irq_ie_no_ready");
      chk_rd(3'd4, 32'h100, "kctrl_ie");
      KEYS = 4'b1100;
      ticks(12);
      expect_v(K_IRQ, 32'h1, "irq_on_press");
      chk_rd(3'd0, 32'h3, "kdata_two_keys");
      chk_rd(3'd4, 32'h101, "kctrl_ie_ready");
      uiDevice = 3'd0;
      rdEn     = 1'b1;
      expect_v(K_IRQ, 32'h1, "irq_before_ack_edge");
      tick();
      rdEn     = 1'b0;
      expect_v(K_IRQ, 32'h0, "irq_after_ack");
      chk_rd(3'd4, 32'h100, "kctrl_after_ack");
      wr(3'd4, 32'h0);

      // Switch overrun and its clearing paths.
      SWITCHES[3] = 1'b1;
      ticks(12);
      chk_rd(3'd1, 32'h8, "sdata_sw3");
      chk_rd(3'd5, 32'h1, "sctrl_ready");
      SWITCHES[3] = 1'b0;
      ticks(12);
      chk_rd(3'd5, 32'h5, "sctrl_overrun");
      wr(3'd5, 32'h0);
      chk_rd(3'd5, 32'h1, "sctrl_ovr_cleared");
      rd_ack(3'd1);
      chk_rd(3'd5, 32'h0, "sctrl_read_clear");

      // Overrun held when in[2]=1; switch interrupt.
      SWITCHES[3] = 1'b1;
      ticks(12);
      SWITCHES[3] = 1'b0;
      ticks(12);
      wr(3'd5, 32'h104);
      expect_v(K_IRQ, 32'h1, "irq_switch");
      chk_rd(3'd5, 32'h105, "sctrl_ovr_kept");
      wr(3'd5, 32'h0);
      rd_ack(3'd1);
      chk_rd(3'd5, 32'h0, "sctrl_reset_state");

      // Debounced change coincides with a clearing SDATA read.
      SWITCHES[5] = 1'b1;
      ticks(9);
      uiDevice = 3'd1;
      rdEn     = 1'b1;
      tick();
      rdEn     = 1'b0;
      chk_rd(3'd5, 32'h1, "collision_sctrl");
      chk_rd(3'd1, 32'h20, "collision_sdata");

      tick();
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
